uart_num_decoder: RTL
=====================

Name: uart_num_decoder

Overview:
- Sits between the UART receiver and the input controller.
- Turns the ASCII byte stream (decimal digits plus delimiters) into 32-bit numeric tokens: a one-cycle decoder_valid pulse with decoder_data.
- Rejects bad characters and out-of-range numbers with a one-cycle decoder_error pulse. Downstream uses this to raise dim_invalid/data_invalid handling.
- No backpressure: downstream always accepts.

Parameters:
- DATA_W, 32, output token width.
- MAX_DIGITS, 10, max digit characters per token; the 11th digit is an overflow.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_valid  input  1  one-cycle strobe, rx_byte valid.
- rx_byte  input  8  received ASCII byte.
- clear  input  1  synchronous flush of any partial token.
- decoder_valid  output  1  one-cycle pulse, token complete.
- decoder_data  output  DATA_W  token value; held until the next decoder_valid.
- decoder_error  output  1  one-cycle pulse, token rejected.
- busy  output  1  high while a token is partially received (state != IDLE).

Behaviour:
- Reset: state=IDLE; acc, digit_cnt, ovf cleared; decoder_valid=0, decoder_data=0, decoder_error=0, busy=0.
- Character classes:
  - DIGIT: 0x30-0x39.
  - DELIM: 0x20 space, 0x09 tab, 0x0D CR, 0x0A LF, 0x2C comma.
  - OTHER: everything else.
- Bytes are considered only in cycles where rx_valid=1.
- States:
  - IDLE:
    - DIGIT -> acc=d, digit_cnt=1, go ACCUM.
    - DELIM -> ignored; consecutive delimiters produce no tokens.
    - OTHER -> decoder_error pulse, go SKIP.
  - ACCUM:
    - DIGIT -> acc=acc*10+d, computed at 36-bit width; digit_cnt++.
    - If bits[35:32] are nonzero, or digit_cnt would exceed MAX_DIGITS: set sticky ovf; acc is don't-care afterwards.
    - DELIM with ovf=0 -> decoder_data<=acc, decoder_valid pulse, go IDLE.
    - DELIM with ovf=1 -> decoder_error pulse, decoder_data unchanged, go IDLE.
    - OTHER -> decoder_error pulse, go SKIP.
  - SKIP: discard DIGIT/OTHER with no further error pulses; DELIM -> IDLE, no pulse.
- Latency: the pulse is registered and asserts in the cycle after the rx_valid cycle carrying the terminating delimiter (or offending byte).
- At most one of decoder_valid/decoder_error is high in any cycle.
- Leading zeros are allowed: "007" -> 7.
- "4294967295" is accepted; "4294967296" is rejected.
- clear=1 -> go IDLE, zero acc/digit_cnt/ovf, no pulses. clear beats a simultaneous rx_valid, and that byte is dropped.
- rx_valid on back-to-back cycles is handled at full rate.
- Reset mid-token discards the token with no output pulse.

Optional Feature:
- Macro SIGNED_INPUT_EN.
- Defined:
  - In IDLE, '-' (0x2D) sets neg and enters ACCUM with acc=0, digit_cnt=0.
  - A DELIM with digit_cnt=0 after '-' -> decoder_error.
  - Range: magnitude ≤ 2^31 if neg, ≤ 2^31-1 otherwise; beyond that -> ovf.
  - Output is two's complement of the magnitude when neg.
  - '-' anywhere else is OTHER.
- Undefined: '-' is OTHER everywhere; range is unsigned 0..2^32-1.

Decomposition:
- parameters.vh gains:
  - ASCII constants: ASC_0, ASC_9, ASC_SP, ASC_TAB, ASC_CR, ASC_LF, ASC_COMMA, ASC_MINUS.
  - Decoder state encodings: DEC_IDLE, DEC_ACCUM, DEC_SKIP.
- One combinational sub-module, ascii_char_class: rx_byte -> is_digit, is_delim, is_minus, digit_val[3:0].
- FSM, accumulator and output registers stay in uart_num_decoder.

Test Plan:
- Bytes "3 4\r\n" -> decoder_valid pulses with 3, then 4. Each pulse occurs exactly one cycle after its delimiter strobe; no extra pulses on CR/LF.
- "4294967295 " -> decoder_data=32'hFFFFFFFF. "4294967296 " -> decoder_error pulse, decoder_data still FFFFFFFF, no decoder_valid.
- "12a5 7 " -> error pulse on the 'a' cycle+1, nothing on the following delimiter, then valid with 7.
- "98" then clear=1 with a simultaneous '7' strobe, then "5 " -> single valid with 5; busy falls the cycle after clear.
- rst asserted after "123" -> all outputs 0 immediately; subsequent "6," yields 6.
- SIGNED_INPUT_EN: "-2147483648 " -> 32'h80000000; "-2147483649 " -> error; "- " -> error; "-0 " -> 0.

Source files
------------

// File: rtl/uart_num_decoder_pkg.sv
// Shared constants for the UART decimal-token decoder: ASCII codes and FSM encodings.
package uart_num_decoder_pkg;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_TAB   = 8'h09;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_COMMA = 8'h2C;
    localparam logic [7:0] ASC_MINUS = 8'h2D;

    localparam int         N_DELIM   = 5;
    localparam logic [8*N_DELIM-1:0] DELIM_SET = {ASC_SP, ASC_TAB, ASC_CR, ASC_LF, ASC_COMMA};

    typedef logic [1:0] dec_state_t;

    localparam dec_state_t DEC_IDLE  = 2'd0;
    localparam dec_state_t DEC_ACCUM = 2'd1;
    localparam dec_state_t DEC_SKIP  = 2'd2;

endpackage

// File: rtl/uart_num_decoder_if.sv
// Byte-stream input and token output bundle of the UART number decoder.
interface uart_num_decoder_if #(
    parameter int DATA_W = 32
);
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              clear;
    logic              decoder_valid;
    logic [DATA_W-1:0] decoder_data;
    logic              decoder_error;
    logic              busy;

    modport master (
        output rx_valid, rx_byte, clear,
        input  decoder_valid, decoder_data, decoder_error, busy
    );

    modport slave (
        input  rx_valid, rx_byte, clear,
        output decoder_valid, decoder_data, decoder_error, busy
    );
endinterface

// File: rtl/uart_num_decoder_ascii_char_class.sv
// Combinational ASCII classifier: decimal digit, token delimiter or minus sign.
module ascii_char_class
    import uart_num_decoder_pkg::*;
(
    input  logic [7:0] rx_byte,
    output logic       is_digit,
    output logic       is_delim,
    output logic       is_minus,
    output logic [3:0] digit_val
);
    logic [N_DELIM-1:0] delim_hit;

    generate
        for (genvar gi = 0; gi < N_DELIM; gi++) begin : g_delim
            assign delim_hit[gi] = (rx_byte == DELIM_SET[gi*8 +: 8]);
        end
    endgenerate

    assign is_digit  = (rx_byte >= ASC_0) && (rx_byte <= ASC_9);
    assign is_delim  = |delim_hit;
    assign is_minus  = (rx_byte == ASC_MINUS);
    // Low nibble of '0'..'9' is the digit value; meaningless for other bytes.
    assign digit_val = rx_byte[3:0];
endmodule

// File: rtl/uart_num_decoder.sv
// ASCII decimal stream -> DATA_W-bit tokens with valid/error pulses.
// Define SIGNED_INPUT_EN to accept a leading '-' and produce two's-complement tokens.
module uart_num_decoder
    import uart_num_decoder_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MAX_DIGITS = 10
)(
    input  logic               clk,
    input  logic               rst,
    uart_num_decoder_if.slave  bus
);
    localparam int ACC_W = DATA_W + 4;
    localparam int CNT_W = $clog2(MAX_DIGITS + 2);

    logic       is_digit, is_delim, is_minus;
    logic [3:0] digit_val;

    ascii_char_class u_class (
        .rx_byte   (bus.rx_byte),
        .is_digit  (is_digit),
        .is_delim  (is_delim),
        .is_minus  (is_minus),
        .digit_val (digit_val)
    );

    dec_state_t        state_reg, state_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0]  digit_cnt_reg, digit_cnt_next;
    logic              ovf_reg, ovf_next;
    logic              neg_reg, neg_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              valid_reg, valid_next;
    logic              error_reg, error_next;

    logic [ACC_W-1:0]  acc_mul;
    logic [CNT_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] token_value;
    logic              mag_ovf;
    logic              minus_start;

    // acc*10 + d; acc is below 2^DATA_W until ovf, so ACC_W bits never wrap.
    assign acc_mul     = (acc_reg << 3) + (acc_reg << 1) + ACC_W'(digit_val);
    assign cnt_inc     = digit_cnt_reg + 1'b1;
    assign token_value = neg_reg ? (DATA_W'(0) - acc_reg[DATA_W-1:0]) : acc_reg[DATA_W-1:0];

`ifdef SIGNED_INPUT_EN
    logic [ACC_W-1:0] mag_lim;
    assign mag_lim     = neg_reg ? (ACC_W'(1) << (DATA_W-1)) : ((ACC_W'(1) << (DATA_W-1)) - 1'b1);
    assign mag_ovf     = (acc_mul > mag_lim);
    assign minus_start = is_minus;
`else
    logic unused_minus;
    assign unused_minus = is_minus;
    assign mag_ovf      = |acc_mul[ACC_W-1:DATA_W];
    assign minus_start  = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        digit_cnt_next = digit_cnt_reg;
        ovf_next       = ovf_reg;
        neg_next       = neg_reg;
        data_next      = data_reg;
        valid_next     = 1'b0;
        error_next     = 1'b0;

        if (bus.clear) begin
            state_next     = DEC_IDLE;
            acc_next       = '0;
            digit_cnt_next = '0;
            ovf_next       = 1'b0;
            neg_next       = 1'b0;
        end else if (bus.rx_valid) begin
            case (state_reg)
                DEC_IDLE: begin
                    if (is_digit) begin
                        acc_next       = ACC_W'(digit_val);
                        digit_cnt_next = CNT_W'(1);
                        ovf_next       = 1'b0;
                        neg_next       = 1'b0;
                        state_next     = DEC_ACCUM;
                    end else if (minus_start) begin
                        acc_next       = '0;
                        digit_cnt_next = '0;
                        ovf_next       = 1'b0;
                        neg_next       = 1'b1;
                        state_next     = DEC_ACCUM;
                    end else if (!is_delim) begin
                        error_next = 1'b1;
                        state_next = DEC_SKIP;
                    end
                end
                DEC_ACCUM: begin
                    if (is_digit) begin
                        // Once ovf is set the token is dead; freeze acc and count.
                        if (!ovf_reg) begin
                            if (mag_ovf || (cnt_inc > CNT_W'(MAX_DIGITS))) begin
                                ovf_next = 1'b1;
                            end else begin
                                acc_next       = acc_mul;
                                digit_cnt_next = cnt_inc;
                            end
                        end
                    end else if (is_delim) begin
                        if (ovf_reg || (digit_cnt_reg == '0)) begin
                            error_next = 1'b1;
                        end else begin
                            valid_next = 1'b1;
                            data_next  = token_value;
                        end
                        state_next = DEC_IDLE;
                    end else begin
                        error_next = 1'b1;
                        state_next = DEC_SKIP;
                    end
                end
                DEC_SKIP: begin
                    if (is_delim) begin
                        state_next = DEC_IDLE;
                    end
                end
                default: state_next = DEC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= DEC_IDLE;
            acc_reg       <= '0;
            digit_cnt_reg <= '0;
            ovf_reg       <= 1'b0;
            neg_reg       <= 1'b0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            digit_cnt_reg <= digit_cnt_next;
            ovf_reg       <= ovf_next;
            neg_reg       <= neg_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            error_reg     <= error_next;
        end
    end

    assign bus.decoder_valid = valid_reg;
    assign bus.decoder_error = error_reg;
    assign bus.decoder_data  = data_reg;
    assign bus.busy          = (state_reg != DEC_IDLE);
endmodule
